// File: rtl/opentdc_pkg.sv
// rtl/opentdc_pkg.sv - register map, event entry layout and status bit positions
package opentdc_pkg;

  // Register window, selected by wbs_adr_i[3:2]
  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COARSE = 2'd3
  } reg_addr_e;

  // Event entry layout (bit 24 is always zero)
  localparam int EV_EDGE_BIT   = 31;
  localparam int EV_FINE_LSB   = 25;
  localparam int EV_FINE_W     = 6;
  localparam int EV_COARSE_LSB = 0;

  // STATUS bits; the fill count sits at [DEPTH_LOG2:0]
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;

  // CTRL bits
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;

endpackage

// File: rtl/opentdc_therm2bin.sv
// rtl/opentdc_therm2bin.sv - thermometer to binary fine-code encoder, bubble tolerant
module opentdc_therm2bin #(
  parameter int NTAPS = 32,
  parameter int FW    = $clog2(NTAPS + 1)
) (
  input  logic [NTAPS-1:0] i_tap,
  output logic [FW-1:0]    o_fine
);

  // Index of the lowest zero tap; scanning downward lets the lowest zero win,
  // so bubbles above it have no effect. All ones encodes as NTAPS.
  always_comb begin
    o_fine = FW'(NTAPS);
    for (int i = NTAPS - 1; i >= 0; i--) begin
      if (!i_tap[i]) begin
        o_fine = FW'(i);
      end
    end
  end

endmodule

// File: rtl/opentdc_evfifo.sv
// rtl/opentdc_evfifo.sv - TDC event encoder, timestamp FIFO and Wishbone readout window
module opentdc_evfifo
  import opentdc_pkg::*;
#(
  parameter int NTAPS      = 32,
  parameter int COARSE_W   = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             wb_clk_i,
  input  logic             rst_n_i,
  input  logic             ev_valid_i,
  input  logic [NTAPS-1:0] ev_tap_i,
  input  logic             ev_edge_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             irq_o
);

  localparam int FW    = $clog2(NTAPS + 1);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [FW-1:0]         w_fine;
  logic [31:0]           w_entry;
  logic [31:0]           w_rdata;
  logic                  w_req;
  logic                  w_wr_ctrl;
  logic                  w_clr;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_unused;

  logic [COARSE_W-1:0]   r_coarse;
  logic                  r_en;
  logic                  r_irq_en;
  logic                  r_ovf;
  logic                  r_irq;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ack;
  reg_addr_e             r_adr;
  logic                  r_we;
  logic                  r_sel0;
  logic [2:0]            r_wdat;

  opentdc_therm2bin #(
    .NTAPS (NTAPS),
    .FW    (FW)
  ) u_therm2bin (
    .i_tap  (ev_tap_i),
    .o_fine (w_fine)
  );

  assign w_unused = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:3]};

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  // A request is only taken while no ack is out, so back-to-back requests are spaced
  assign w_req      = wbs_stb_i & wbs_cyc_i & ~r_ack;
  // Register side effects are committed at the end of the ack cycle
  assign w_wr_ctrl  = r_ack & r_we & r_sel0 & (r_adr == REG_CTRL);
  assign w_clr      = w_wr_ctrl & r_wdat[CTRL_CLR_BIT];
  assign w_pop      = r_ack & ~r_we & (r_adr == REG_DATA) & ~w_empty;
  assign w_push_req = ev_valid_i & r_en;
  assign w_push     = w_push_req & (~w_full | w_pop);

  // Pack edge, fine code and the coarse value current in the event cycle
  always_comb begin
    w_entry = '0;
    w_entry[EV_EDGE_BIT] = ev_edge_i;
    w_entry[EV_FINE_LSB +: FW] = w_fine;
    w_entry[EV_COARSE_LSB +: COARSE_W] = r_coarse;
  end

  // Latch the request and raise a single-cycle ack
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      r_ack  <= 1'b0;
      r_adr  <= REG_STATUS;
      r_we   <= 1'b0;
      r_sel0 <= 1'b0;
      r_wdat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_adr  <= reg_addr_e'(wbs_adr_i[3:2]);
        r_we   <= wbs_we_i;
        r_sel0 <= wbs_sel_i[0];
        r_wdat <= wbs_dat_i[2:0];
      end
    end
  end

  // Read mux over the register window, evaluated during the ack cycle
  always_comb begin
    w_rdata = '0;
    case (r_adr)
      REG_STATUS: begin
        w_rdata[DEPTH_LOG2:0]  = r_count;
        w_rdata[ST_EMPTY_BIT]  = w_empty;
        w_rdata[ST_FULL_BIT]   = w_full;
        w_rdata[ST_OVF_BIT]    = r_ovf;
      end
      REG_DATA: begin
        if (!w_empty) begin
          w_rdata = r_mem[r_rd_ptr];
        end
      end
      REG_CTRL: begin
        w_rdata[CTRL_EN_BIT]    = r_en;
        w_rdata[CTRL_IRQEN_BIT] = r_irq_en;
      end
      REG_COARSE: begin
        w_rdata[COARSE_W-1:0] = r_coarse;
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_ack ? w_rdata : '0;

  // CTRL enable bits; clr is a pulse and is never stored
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en     <= r_wdat[CTRL_EN_BIT];
      r_irq_en <= r_wdat[CTRL_IRQEN_BIT];
    end
  end

  // Free-running coarse timestamp, wraps naturally
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i || w_clr) begin
      r_coarse <= '0;
    end else if (r_en) begin
      r_coarse <= r_coarse + COARSE_W'(1);
    end
  end

  // FIFO pointers, fill count and sticky overflow; clr beats a same-cycle push
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i || w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only visible through the count-guarded read path
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Level interrupt, registered from the current fill state
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & ~w_empty;
    end
  end

  assign irq_o = r_irq;

endmodule
